modified_barret_reduction: RTL and testbench

//   Pipelined Barrett modular reducer: y = x mod q for a 2k-bit operand, e.g. the

---
 rtl/modified_barret_reduction.sv | 65 ++++++
 tb/tb_modified_barret_reduction.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/modified_barret_reduction.sv
// Three-stage Barrett reducer: y = x mod q for a 2k-bit operand, one result per clock.
// The modulus and the Barrett constant MU are fixed at elaboration.
module modified_barret_reduction #(
    parameter int unsigned q = 65537,
    parameter int          k = $clog2(q)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    input  logic [2*k-1:0] x,
    output logic           out_valid,
    output logic [k:0]     y
);

    localparam int          STAGES = 3;
    localparam logic [k:0]  MU     = (k+1)'((64'd1 << (2*k)) / 64'(q));
    localparam logic [k+1:0] QR    = (k+2)'(q);

    logic [STAGES:1]  r_vld_pipe;
    logic [k+1:0]     r_x_lo;
    logic [2*k+1:0]   r_q2;
    logic [k+1:0]     r_r;
    logic [k:0]       r_y;

    logic [k:0]       w_q1;
    logic [2*k+1:0]   w_q2;
    logic [k:0]       w_q3;
    logic [k+1:0]     w_qq;
    logic [k+1:0]     w_r;
    logic [k+1:0]     w_r1;
    logic [k+1:0]     w_r2;

    // S1: quotient estimate product
    assign w_q1 = (k+1)'(x >> (k-1));
    assign w_q2 = (2*k+2)'(w_q1) * (2*k+2)'(MU);

    // S2: only the low k+2 bits of x - q3*q matter since 0 <= r < 3q < 2^(k+2)
    assign w_q3 = (k+1)'(r_q2 >> (k+1));
    assign w_qq = (k+2)'(w_q3) * QR;
    assign w_r  = r_x_lo - w_qq;

    // S3: two conditional subtractions bring r into [0, q)
    assign w_r1 = (r_r  >= QR) ? (r_r  - QR) : r_r;
    assign w_r2 = (w_r1 >= QR) ? (w_r1 - QR) : w_r1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_pipe <= '0;
            r_x_lo     <= '0;
            r_q2       <= '0;
            r_r        <= '0;
            r_y        <= '0;
        end else begin
            r_vld_pipe <= {r_vld_pipe[STAGES-1:1], in_valid};
            r_x_lo     <= x[k+1:0];
            r_q2       <= w_q2;
            r_r        <= w_r;
            r_y        <= (k+1)'(w_r2);
        end
    end

    assign out_valid = r_vld_pipe[STAGES];
    assign y         = r_y;

endmodule

// File: tb/tb_modified_barret_reduction.sv
// Directed and random checks of the Barrett reducer against a x % q reference
// with a 3-deep valid/expected-value pipeline model.
module tb_modified_barret_reduction;

    localparam int unsigned Q = 65537;
    localparam int          K = 17;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic [2*K-1:0]  x;
    logic            out_valid;
    logic [K:0]      y;

    int checks;
    int errors;

    logic       mv [3];
    logic [K:0] me [3];

    typedef struct {
        logic [2*K-1:0] x;
        logic [K:0]     y;
    } vec_t;

    vec_t tbl [15];

    modified_barret_reduction #(.q(Q)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .x         (x),
        .out_valid (out_valid),
        .y         (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one slot, advance one edge, then compare against the model's stage-3 entry.
    task automatic step(input logic v, input logic [2*K-1:0] xv, input logic [K:0] ev);
        in_valid = v;
        x        = xv;
        @(posedge clk);
        mv[2] = mv[1]; me[2] = me[1];
        mv[1] = mv[0]; me[1] = me[0];
        mv[0] = v;     me[0] = ev;
        #1;
        chk("out_valid", 64'(out_valid), 64'(mv[2]));
        if (mv[2]) chk("y", 64'(y), 64'(me[2]));
    endtask

    function automatic logic [K:0] ref_mod(input logic [2*K-1:0] xv);
        longint unsigned t;
        t = 64'(xv) % 64'(Q);
        return (K+1)'(t);
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 3; i++) begin
            mv[i] = 1'b0;
            me[i] = '0;
        end
    endtask

    initial begin
        logic [2*K-1:0] rx;
        checks   = 0;
        errors   = 0;
        in_valid = 1'b0;
        x        = '0;
        clear_model();

        tbl[0]  = '{34'd21,          18'd21};
        tbl[1]  = '{34'd10,          18'd10};
        tbl[2]  = '{34'd0,           18'd0};
        tbl[3]  = '{34'd65536,       18'd65536};
        tbl[4]  = '{34'd65537,       18'd0};
        tbl[5]  = '{34'd66287,       18'd750};
        tbl[6]  = '{34'd262240,      18'd92};
        tbl[7]  = '{34'd596583,      18'd6750};
        tbl[8]  = '{34'd4294967296,  18'd1};
        tbl[9]  = '{34'h3_FFFF_FFFF, 18'd3};
        tbl[10] = '{34'd131073,      18'd65536};
        tbl[11] = '{34'd131074,      18'd0};
        tbl[12] = '{34'd1,           18'd1};
        tbl[13] = '{34'd4295098369,  18'd0};
        tbl[14] = '{34'h3_FFFF_FFFC, 18'd0};

        // Reset state
        rst_n = 1'b0;
        #2;
        chk("rst out_valid", 64'(out_valid), 64'd0);
        chk("rst y", 64'(y), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Directed vectors, one per slot, back-to-back
        foreach (tbl[i]) step(1'b1, tbl[i].x, tbl[i].y);
        for (int i = 0; i < 3; i++) step(1'b0, '0, '0);

        // Same vectors with idle slots in between
        foreach (tbl[i]) begin
            step(1'b1, tbl[i].x, tbl[i].y);
            step(1'b0, 34'h1_2345_6789, '0);
        end
        for (int i = 0; i < 3; i++) step(1'b0, '0, '0);

        // Streaming random operands
        for (int i = 0; i < 1000; i++) begin
            rx = {2'($urandom), 32'($urandom)};
            step(1'b1, rx, ref_mod(rx));
        end

        // Random valid gaps
        for (int i = 0; i < 300; i++) begin
            rx = {2'($urandom), 32'($urandom)};
            step(1'($urandom_range(0, 1)), rx, ref_mod(rx));
        end
        for (int i = 0; i < 3; i++) step(1'b0, '0, '0);

        // Reset with two operands still in flight and one on the output
        step(1'b1, 34'd66287, 18'd750);
        step(1'b1, 34'd262240, 18'd92);
        step(1'b1, 34'd596583, 18'd6750);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst out_valid", 64'(out_valid), 64'd0);
        chk("midrst y", 64'(y), 64'd0);
        clear_model();
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("inrst out_valid", 64'(out_valid), 64'd0);
        #2 rst_n = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) step(1'b0, '0, '0);
        step(1'b1, 34'h3_FFFF_FFFF, 18'd3);
        step(1'b1, 34'd4294967296, 18'd1);
        for (int i = 0; i < 4; i++) step(1'b0, '0, '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
